// File: rtl/md_unit_pkg.sv
// -----------------------------------------------------------------------------
// md_unit_pkg
// Shared definitions for the multiply/divide unit: operation encodings, FSM
// state type, HI/LO read-select constants and a helper that classifies the
// multi-cycle operations.
// -----------------------------------------------------------------------------
package md_unit_pkg;

    // Operation encodings (codes 6 and 7 are unused and behave as no-ops)
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // md_out read select
    localparam logic RD_SEL_LO = 1'b0;
    localparam logic RD_SEL_HI = 1'b1;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // True for the operations that occupy the unit for several cycles
    function automatic logic is_multi_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// -----------------------------------------------------------------------------
// md_unit_if
// Request / response bundle between the execute stage and the multiply/divide
// unit.
//   master : drives start, md_op, src_a, src_b, cancel, rd_sel
//   slave  : drives md_out, busy, stall_req, hi, lo
// -----------------------------------------------------------------------------
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       md_op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             cancel;
    logic             rd_sel;
    logic [WIDTH-1:0] md_out;
    logic             busy;
    logic             stall_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, md_op, src_a, src_b, cancel, rd_sel,
        input  md_out, busy, stall_req, hi, lo
    );

    modport slave (
        input  start, md_op, src_a, src_b, cancel, rd_sel,
        output md_out, busy, stall_req, hi, lo
    );
endinterface

// File: rtl/md_unit_arith.sv
// -----------------------------------------------------------------------------
// md_unit_arith
// Purely combinational multiply / divide datapath.
//   md_op       : operation code (selects signed/unsigned and mul/div)
//   src_a/src_b : operands (dividend/multiplicand, divisor/multiplier)
//   res_hi      : product upper half, or remainder
//   res_lo      : product lower half, or quotient
//   div_by_zero : divide op with a zero divisor (result must not be committed)
// -----------------------------------------------------------------------------
module md_unit_arith
    import md_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             div_by_zero
);

    logic                   is_signed;
    logic                   is_div;
    logic                   neg_a;
    logic                   neg_b;
    logic [2*WIDTH-1:0]     ext_a;
    logic [2*WIDTH-1:0]     ext_b;
    logic [2*WIDTH-1:0]     product;
    logic [WIDTH-1:0]       mag_a;
    logic [WIDTH-1:0]       mag_b;
    logic [WIDTH-1:0]       safe_b;
    logic [WIDTH-1:0]       quot_mag;
    logic [WIDTH-1:0]       rem_mag;
    logic [WIDTH-1:0]       quot;
    logic [WIDTH-1:0]       rem;

    assign is_signed = (md_op == MD_MULT) || (md_op == MD_DIV);
    assign is_div    = (md_op == MD_DIV)  || (md_op == MD_DIVU);
    assign neg_a     = is_signed & src_a[WIDTH-1];
    assign neg_b     = is_signed & src_b[WIDTH-1];

    // Sign/zero extension to 2*WIDTH makes one truncated multiply correct for
    // both the signed and the unsigned product.
    assign ext_a   = {{WIDTH{neg_a}}, src_a};
    assign ext_b   = {{WIDTH{neg_b}}, src_b};
    assign product = ext_a * ext_b;

    // Signed divide works on magnitudes. |min_int| wraps to 2^(WIDTH-1) as an
    // unsigned value, so min_int / -1 naturally yields lo = min_int, hi = 0.
    assign mag_a  = neg_a ? (~src_a + 1'b1) : src_a;
    assign mag_b  = neg_b ? (~src_b + 1'b1) : src_b;
    // Keep the divider away from a zero divisor; the result is discarded then.
    assign safe_b = (mag_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;

    assign quot_mag = mag_a / safe_b;
    assign rem_mag  = mag_a % safe_b;

    // Quotient truncates toward zero; remainder takes the dividend's sign.
    assign quot = (neg_a ^ neg_b) ? (~quot_mag + 1'b1) : quot_mag;
    assign rem  = neg_a ? (~rem_mag + 1'b1) : rem_mag;

    assign res_hi      = is_div ? rem  : product[2*WIDTH-1:WIDTH];
    assign res_lo      = is_div ? quot : product[WIDTH-1:0];
    assign div_by_zero = is_div && (src_b == '0);

endmodule

// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit
// Multiply/divide unit holding the architectural HI/LO registers.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : md_unit_if slave port (start/md_op/src_a/src_b/cancel/rd_sel in,
//           md_out/busy/stall_req/hi/lo out)
// The result of a multi-cycle op is computed when it is accepted, held in the
// pending registers, and copied to HI/LO when the busy countdown expires.
// -----------------------------------------------------------------------------
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    md_unit_if.slave   bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pending_hi_q, pending_hi_d;
    logic [WIDTH-1:0] pending_lo_q, pending_lo_d;
    logic             pending_dz_q, pending_dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             div_by_zero;

    md_unit_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .md_op       (bus.md_op),
        .src_a       (bus.src_a),
        .src_b       (bus.src_b),
        .res_hi      (res_hi),
        .res_lo      (res_lo),
        .div_by_zero (div_by_zero)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pending_hi_d = pending_hi_q;
        pending_lo_d = pending_lo_q;
        pending_dz_d = pending_dz_q;
        hi_d         = hi_q;
        lo_d         = lo_q;

        if (bus.cancel) begin
            // Flush beats everything, including a same-cycle start or commit.
            state_d      = MD_IDLE;
            cnt_d        = '0;
            pending_hi_d = '0;
            pending_lo_d = '0;
            pending_dz_d = 1'b0;
        end else begin
            unique case (state_q)
                MD_IDLE: begin
                    if (bus.start) begin
                        if (is_multi_op(bus.md_op)) begin
                            pending_hi_d = res_hi;
                            pending_lo_d = res_lo;
                            pending_dz_d = div_by_zero;
                            cnt_d        = ((bus.md_op == MD_MULT) || (bus.md_op == MD_MULTU))
                                         ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                            state_d      = MD_BUSY;
                        end else if (bus.md_op == MD_MTHI) begin
                            hi_d = bus.src_a;
                        end else if (bus.md_op == MD_MTLO) begin
                            lo_d = bus.src_a;
                        end
                    end
                end
                MD_BUSY: begin
                    // start is ignored for the whole busy window, commit cycle included
                    if (cnt_q == CNT_W'(1)) begin
                        state_d      = MD_IDLE;
                        cnt_d        = '0;
                        if (!pending_dz_q) begin
                            hi_d = pending_hi_q;
                            lo_d = pending_lo_q;
                        end
                        pending_hi_d = '0;
                        pending_lo_d = '0;
                        pending_dz_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= MD_IDLE;
            cnt_q        <= '0;
            pending_hi_q <= '0;
            pending_lo_q <= '0;
            pending_dz_q <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_hi_q <= pending_hi_d;
            pending_lo_q <= pending_lo_d;
            pending_dz_q <= pending_dz_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
        end
    end

    assign bus.busy      = (state_q == MD_BUSY);
    assign bus.stall_req = (state_q == MD_BUSY) || (bus.start && is_multi_op(bus.md_op));
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    // Architectural registers only: pending results are never visible here.
    assign bus.md_out    = (bus.rd_sel == RD_SEL_HI) ? hi_q : lo_q;

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit holding architectural HI/LO registers.
- It is the next-generation companion to the single-cycle datapath and is instantiated beside the ALU in the pipelined CPU's execute stage.
- It accepts mult/multu/div/divu/mthi/mtlo and serves mfhi/mflo reads.
- Multi-cycle ops run for a configurable latency and drive a busy/stall handshake so that decode can stall dependent MD instructions.

Parameters:
- WIDTH, 32, operand and HI/LO width (≥ 8).
- MULT_CYCLES, 5, busy cycles for mult/multu (≥ 1).
- DIV_CYCLES, 10, busy cycles for div/divu (≥ 1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request valid this cycle.
- md_op  in  3  operation code; encoding in shared package.
- src_a  in  WIDTH  rs operand (dividend / multiplicand / mt data).
- src_b  in  WIDTH  rt operand.
- cancel  in  1  abort in-flight op (exception flush).
- rd_sel  in  1  0 = LO, 1 = HI for md_out.
- md_out  out  WIDTH  mfhi/mflo read data.
- busy  out  1  multi-cycle op in flight.
- stall_req  out  1  busy | (start & md_op is MULT/MULTU/DIV/DIVU).
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset: while reset = 0, the state is IDLE and counter, hi, lo, the pending registers and busy are all 0. Reset may assert mid-operation; the in-flight result is discarded.
- FSM has two states, IDLE and BUSY.
- IDLE, start = 1, op ∈ {MULT, MULTU, DIV, DIVU}, cancel = 0:
  - At edge T, compute the result into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES, go to BUSY.
  - busy = 1 from T for exactly N cycles.
  - At edge T+N: hi/lo ← pending, busy → 0, state → IDLE.
- IDLE, start = 1, op MTHI or MTLO: hi (resp. lo) ← src_a at the next edge. busy stays 0. The other register is unchanged.
- BUSY: counter decrements each edge. start is ignored: no effect on state, hi/lo or the pending result. Upstream must honour stall_req.
- Commit-cycle restart: on the final BUSY cycle (counter = 1) a start is still ignored. A new op is accepted only in IDLE.
- cancel = 1 (any state):
  - Next edge: state → IDLE, counter → 0, pending result dropped, hi/lo unchanged.
  - cancel with start in the same cycle: cancel wins and start is dropped, including MTHI/MTLO.
  - cancel on the commit edge: commit suppressed.
- Arithmetic:
  - MULT: signed WIDTH×WIDTH → 2·WIDTH product; hi = upper WIDTH bits, lo = lower. MULTU is the unsigned equivalent.
  - DIV: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - Signed overflow (min_int / −1): lo = min_int, hi = 0.
  - DIVU: unsigned quotient and remainder.
  - src_b = 0 for DIV/DIVU: full DIV_CYCLES busy period runs, then hi/lo keep their previous values (no commit).
- md_out = rd_sel ? hi : lo, combinational from the architectural registers only. It never exposes pending values and is valid while busy (returns the old value).
- Undefined md_op codes (6, 7) with start: treated as no-op, no state change.
- Counter width is $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).

Decomposition:
- Shared package / `const_def.v`:
  - md_op encodings: MD_MULT = 0, MD_MULTU = 1, MD_DIV = 2, MD_DIVU = 3, MD_MTHI = 4, MD_MTLO = 5.
  - FSM state constants MD_IDLE and MD_BUSY.
  - RD_SEL_LO / RD_SEL_HI.
- One natural sub-module, md_arith: purely combinational signed/unsigned multiply and divide. It produces {res_hi, res_lo, div_by_zero} and keeps the sequencing FSM separate from the arithmetic.

Test Plan:
- Reset then MULT, src_a = 0xFFFFFFFE (−2), src_b = 3 -> busy high for exactly 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFFA, busy = 0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 5 cycles hi = 0xFFFFFFFE, lo = 0x00000001; md_out reads old lo during busy.
- DIV −7 / 2 -> after 10 cycles lo = 0xFFFFFFFD (−3), hi = 0xFFFFFFFF (−1); DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- MTHI 0x1234 in IDLE -> next edge hi = 0x1234, busy stays 0; DIVU x / 0 with hi = 0x1234, lo = 0x55 -> 10 busy cycles, then hi/lo unchanged.
- Start DIV, cancel on busy cycle 4 (and cancel + start together in IDLE) -> next edge busy = 0, hi/lo unchanged, no later commit; start asserted during busy has no effect.
- Assert reset low mid-MULT (cycle 2) -> hi = lo = 0 and busy = 0 immediately (asynchronous); after release, MULT 6 × 7 -> lo = 42, hi = 0.
